// File: rtl/baud_pkg.sv
// Shared constants and helpers for the fractional baud generator.
package baud_pkg;

  localparam int unsigned DIV_W_DEF   = 16;
  localparam int unsigned FRAC_W_DEF  = 4;
  localparam int unsigned NUM_PRESETS = 8;

  // Preset baud rates selected by bd_rate_i = 0..7.
  localparam int unsigned BAUD_PRESET [NUM_PRESETS] = '{
    1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200
  };

  // Fixed-point divisor {int, frac}: round(clk_hz * 2^frac_w / (oversample * baud)).
  function automatic longint unsigned calc_div(input longint unsigned clk_hz,
                                               input longint unsigned oversample,
                                               input longint unsigned baud,
                                               input longint unsigned frac_w);
    longint unsigned num;
    longint unsigned den;
    num = clk_hz << frac_w;
    den = oversample * baud;
    return (64'd2 * num + den) / (64'd2 * den);
  endfunction

  // Oversample ratio must be even (mid-bit tick) and at least 4.
  function automatic bit oversample_ok(input int unsigned os);
    return (os >= 4) && ((os % 2) == 0);
  endfunction

endpackage

// File: rtl/baud_frac_div.sv
// Fractional divider core: period counter, fractional accumulator and the
// pending/active divisor handover. Emits the registered oversample tick and a
// combinational wrap strobe aligned with the edge that raises it.
module baud_frac_div #(
  parameter int unsigned                 DIV_W    = 16,
  parameter int unsigned                 FRAC_W   = 4,
  parameter logic [DIV_W+FRAC_W-1:0]     DivReset = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_i,
  input  logic                    restart_i,
  input  logic [DIV_W+FRAC_W-1:0] div_next_i,
  output logic                    tick_os_o,
  output logic                    wrap_o,
  output logic [DIV_W+FRAC_W-1:0] div_active_o
);

  localparam int unsigned DW = DIV_W + FRAC_W;
  localparam int unsigned PW = DIV_W + 1;

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [DW-1:0]     div_q, div_d;
  logic              tick_q, tick_d;

  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic [FRAC_W:0]   acc_sum;
  logic [PW-1:0]     last_cnt;
  logic              at_end;
  logic              wrap;

  // Current period length is int + carry out of the fractional accumulator.
  always_comb begin
    div_int  = div_q[DW-1:FRAC_W];
    div_frac = div_q[FRAC_W-1:0];
    acc_sum  = {1'b0, acc_q} + {1'b0, div_frac};
    last_cnt = {1'b0, div_int} + PW'(acc_sum[FRAC_W]) - PW'(1);
    at_end   = ({1'b0, cnt_q} == last_cnt);
    wrap     = enable_i && !restart_i && at_end;
  end

  // Next-state: restart realigns phase, otherwise count while enabled.
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    div_d  = div_q;
    tick_d = 1'b0;
    if (restart_i) begin
      cnt_d = '0;
      acc_d = '0;
      div_d = div_next_i;
    end else if (enable_i) begin
      if (at_end) begin
        cnt_d  = '0;
        acc_d  = acc_sum[FRAC_W-1:0];
        div_d  = div_next_i;  // pending divisor only takes effect on a full period boundary
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      div_q  <= DivReset;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick_os_o    = tick_q;
  assign wrap_o       = wrap;
  assign div_active_o = div_q;

endmodule

// File: rtl/baud_frac_gen.sv
// Fractional baud generator top: divisor source selection (preset table or
// runtime custom register), oversample phase counter and bit/mid-bit ticks.
// Optional feature macro: BAUD_HALF_TICK_EN adds the tick_half_o mid-bit output.
module baud_frac_gen
  import baud_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 15360000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = DIV_W_DEF,
  parameter int unsigned FRAC_W     = FRAC_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_i,
  input  logic [2:0]              bd_rate_i,
  input  logic                    cfg_sel_i,
  input  logic                    div_wr_i,
  input  logic [DIV_W+FRAC_W-1:0] div_wdata_i,
  input  logic                    restart_i,
  output logic                    tick_os_o,
  output logic                    tick_bit_o,
`ifdef BAUD_HALF_TICK_EN
  output logic                    tick_half_o,
`endif
  output logic [DIV_W+FRAC_W-1:0] div_active_o,
  output logic                    cfg_err_o
);

  localparam int unsigned DW   = DIV_W + FRAC_W;
  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OsLast = OS_W'(OVERSAMPLE - 1);
  localparam logic [DW-1:0] DivReset = DW'(calc_div(64'(CLK_HZ), 64'(OVERSAMPLE),
                                                    64'(BAUD_PRESET[0]), 64'(FRAC_W)));

  if (!oversample_ok(OVERSAMPLE)) begin : g_bad_oversample
    $error("OVERSAMPLE must be even and at least 4");
  end

  // Preset divisors are fixed at elaboration from the clock and baud table.
  logic [DW-1:0] preset_tbl [NUM_PRESETS];
  for (genvar g = 0; g < NUM_PRESETS; g++) begin : g_preset
    assign preset_tbl[g] = DW'(calc_div(64'(CLK_HZ), 64'(OVERSAMPLE),
                                        64'(BAUD_PRESET[g]), 64'(FRAC_W)));
  end

  logic [DW-1:0]   custom_q, custom_d;
  logic            cfg_err_q, cfg_err_d;
  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic            tick_bit_q, tick_bit_d;
  logic            wr_ok;
  logic            wrap;
  logic [DW-1:0]   div_next;

  // Custom write acceptance; a same-cycle accepted write is visible to the
  // divider immediately so a coincident restart applies it.
  always_comb begin
    wr_ok     = div_wr_i && (div_wdata_i[DW-1:FRAC_W] >= DIV_W'(2));
    custom_d  = wr_ok ? div_wdata_i : custom_q;
    cfg_err_d = div_wr_i && !wr_ok;
    div_next  = cfg_sel_i ? custom_d : preset_tbl[bd_rate_i];
  end

  // Custom divisor register and reject pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      custom_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      custom_q  <= custom_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  baud_frac_div #(
    .DIV_W    (DIV_W),
    .FRAC_W   (FRAC_W),
    .DivReset (DivReset)
  ) u_div (
    .clk          (clk),
    .reset        (reset),
    .enable_i     (enable_i),
    .restart_i    (restart_i),
    .div_next_i   (div_next),
    .tick_os_o    (tick_os_o),
    .wrap_o       (wrap),
    .div_active_o (div_active_o)
  );

  // Oversample phase counter; bit tick rides on the oversample tick that wraps it.
  always_comb begin
    os_cnt_d   = os_cnt_q;
    tick_bit_d = 1'b0;
    if (restart_i) begin
      os_cnt_d = '0;
    end else if (wrap) begin
      if (os_cnt_q == OsLast) begin
        os_cnt_d   = '0;
        tick_bit_d = 1'b1;
      end else begin
        os_cnt_d = os_cnt_q + 1'b1;
      end
    end
  end

  // Phase counter and bit tick registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      os_cnt_q   <= '0;
      tick_bit_q <= 1'b0;
    end else begin
      os_cnt_q   <= os_cnt_d;
      tick_bit_q <= tick_bit_d;
    end
  end

`ifdef BAUD_HALF_TICK_EN
  localparam logic [OS_W-1:0] OsHalfPrev = OS_W'(OVERSAMPLE / 2 - 1);

  logic tick_half_q, tick_half_d;

  // Mid-bit tick on the oversample tick that moves the phase into the second half.
  always_comb begin
    tick_half_d = wrap && (os_cnt_q == OsHalfPrev);
  end

  // Mid-bit tick register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_half_q <= 1'b0;
    end else begin
      tick_half_q <= tick_half_d;
    end
  end

  assign tick_half_o = tick_half_q;
`endif

  assign tick_bit_o = tick_bit_q;
  assign cfg_err_o  = cfg_err_q;

endmodule

// File: tb/tb_baud_frac_gen.sv
// Directed plus randomized bench for baud_frac_gen. Expected tick times come
// from the closed form: n-th tick of a segment = t0 + n*int + floor((a0 + n*frac)/2^FRAC_W).
module tb_baud_frac_gen;

  localparam int unsigned DIV_W      = 16;
  localparam int unsigned FRAC_W     = 4;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DW         = DIV_W + FRAC_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [2:0]    bd_rate;
  logic          cfg_sel;
  logic          div_wr;
  logic [DW-1:0] div_wdata;
  logic          restart;
  logic          tick_os;
  logic          tick_bit;
`ifdef BAUD_HALF_TICK_EN
  logic          tick_half;
`endif
  logic [DW-1:0] div_active;
  logic          cfg_err;

  always #5 clk = ~clk;

  baud_frac_gen #(
    .CLK_HZ     (15360000),
    .OVERSAMPLE (OVERSAMPLE),
    .DIV_W      (DIV_W),
    .FRAC_W     (FRAC_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable_i     (enable),
    .bd_rate_i    (bd_rate),
    .cfg_sel_i    (cfg_sel),
    .div_wr_i     (div_wr),
    .div_wdata_i  (div_wdata),
    .restart_i    (restart),
    .tick_os_o    (tick_os),
    .tick_bit_o   (tick_bit),
`ifdef BAUD_HALF_TICK_EN
    .tick_half_o  (tick_half),
`endif
    .div_active_o (div_active),
    .cfg_err_o    (cfg_err)
  );

  int     n_assert = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  bit     stray    = 1'b0;
  int     os_m     = 0;
  longint seg_t0   = 0;
  longint last_t   = 0;
  int     si = 0, sf = 0, sa0 = 0, sn = 0;
  longint tt [0:31];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle; outputs are observed on the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (tick_bit && !tick_os) stray = 1'b1;
  endtask

  task automatic wait_until(input longint c);
    while (cyc < c) step();
  endtask

  // New divisor segment with the accumulator carried over from the previous one.
  task automatic seg_cont(input longint t0, input int w);
    sa0    = (sa0 + sn * sf) % (1 << FRAC_W);
    seg_t0 = t0;
    si     = w >> FRAC_W;
    sf     = w % (1 << FRAC_W);
    sn     = 0;
  endtask

  // New segment after reset or restart: accumulator and phase cleared.
  task automatic seg_fresh(input longint t0, input int w);
    sa0    = 0;
    sn     = 0;
    seg_t0 = t0;
    si     = w >> FRAC_W;
    sf     = w % (1 << FRAC_W);
    os_m   = 0;
  endtask

  function automatic longint exp_tick(input int n);
    return seg_t0 + longint'(n) * si + longint'((sa0 + n * sf) >> FRAC_W);
  endfunction

  task automatic run_ticks(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      k = 0;
      do begin
        step();
        k++;
      end while (tick_os !== 1'b1 && k < 20000);
      sn++;
      os_m = (os_m + 1) % OVERSAMPLE;
      chk("tick_seen", tick_os, 1);
      chk("tick_time", cyc, exp_tick(sn));
      chk("tick_bit", tick_bit, os_m == 0);
`ifdef BAUD_HALF_TICK_EN
      chk("tick_half", tick_half, os_m == OVERSAMPLE / 2);
`endif
      tt[i]  = cyc;
      last_t = cyc;
    end
    chk("stray_bit", stray, 0);
  endtask

  task automatic enable_gap(input int off, input int g);
    wait_until(last_t + off);
    enable = 1'b0;
    repeat (g) step();
    chk("gap_no_tick", tick_os, 0);
    enable = 1'b1;
    seg_t0 += g;
  endtask

  task automatic do_restart(input int off, input int w);
    longint rs;
    wait_until(last_t + off);
    restart = 1'b1;
    rs = cyc;
    step();
    restart = 1'b0;
    chk("restart_no_tick", tick_os, 0);
    seg_fresh(rs + 1, w);
  endtask

  initial begin
    longint s;
    int     nines;
    int     w, ri, rf;

    reset = 1'b1; enable = 1'b1; bd_rate = 3'd0; cfg_sel = 1'b0;
    div_wr = 1'b0; div_wdata = '0; restart = 1'b0;
    repeat (3) step();
    chk("rst_tick_os", tick_os, 0);
    chk("rst_tick_bit", tick_bit, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_div_active", div_active, 800 * 16);

    // 1200 baud: 800-cycle oversample, bit tick every 16th.
    reset = 1'b0;
    seg_fresh(cyc, 800 * 16);
    run_ticks(16);

    // Restart mid-period with phase counter nonzero.
    run_ticks(3);
    do_restart(300, 800 * 16);
    run_ticks(16);

    // Restart on the cycle that would wrap suppresses that tick.
    do_restart(799, 800 * 16);
    run_ticks(2);

    // Enable low for 50 cycles mid-period.
    enable_gap(200, 50);
    run_ticks(2);

    // Switch to 115200 mid-period: current period finishes at 800.
    wait_until(last_t + 100);
    bd_rate = 3'd7;
    repeat (5) step();
    chk("pending_hold", div_active, 800 * 16);
    run_ticks(1);
    chk("div_115200", div_active, 8 * 16 + 5);
    seg_cont(last_t, 8 * 16 + 5);
    s = seg_t0;
    run_ticks(16);
    nines = 0;
    for (int i = 0; i < 16; i++) begin
      if (tt[i] - ((i == 0) ? s : tt[i-1]) == 9) nines++;
    end
    chk("nine_periods", nines, 5);
    chk("span16", tt[15] - s, 133);

    // Custom {10,8} written mid-period.
    wait_until(last_t + 3);
    cfg_sel = 1'b1; div_wr = 1'b1; div_wdata = DW'(10 * 16 + 8);
    step();
    div_wr = 1'b0;
    chk("good_wr_no_err", cfg_err, 0);
    chk("custom_pending", div_active, 8 * 16 + 5);
    run_ticks(1);
    chk("custom_active", div_active, 10 * 16 + 8);
    seg_cont(last_t, 10 * 16 + 8);
    run_ticks(6);

    // Rejected write: int = 1.
    wait_until(last_t + 2);
    div_wr = 1'b1; div_wdata = DW'(1 * 16 + 3);
    step();
    div_wr = 1'b0;
    chk("cfg_err_pulse", cfg_err, 1);
    step();
    chk("cfg_err_clear", cfg_err, 0);
    chk("bad_wr_div", div_active, 10 * 16 + 8);
    run_ticks(4);

    // Randomized custom divisors with gaps and restarts.
    for (int r = 0; r < 4; r++) begin
      ri = int'($urandom_range(12, 2));
      rf = int'($urandom_range(15, 0));
      w  = ri * 16 + rf;
      div_wr = 1'b1; div_wdata = DW'(w);
      step();
      div_wr = 1'b0;
      run_ticks(1);
      chk("rand_div_active", div_active, w);
      seg_cont(last_t, w);
      run_ticks(6);
      enable_gap(int'($urandom_range(ri - 1, 0)), int'($urandom_range(40, 1)));
      run_ticks(3);
      do_restart(int'($urandom_range(ri - 1, 0)), w);
      run_ticks(4);
    end

    // Write together with restart: applied by that restart.
    wait_until(last_t);
    div_wr = 1'b1; div_wdata = DW'(4 * 16); restart = 1'b1;
    step();
    div_wr = 1'b0; restart = 1'b0;
    chk("wr_restart_div", div_active, 4 * 16);
    chk("wr_restart_no_tick", tick_os, 0);
    seg_fresh(cyc, 4 * 16);
    run_ticks(3);

    // Reset on the wrap cycle, with a bad write pending.
    wait_until(last_t + 3);
    reset = 1'b1; div_wr = 1'b1; div_wdata = DW'(16);
    step();
    div_wr = 1'b0;
    chk("mid_rst_tick_os", tick_os, 0);
    chk("mid_rst_tick_bit", tick_bit, 0);
    chk("mid_rst_cfg_err", cfg_err, 0);
    chk("mid_rst_div", div_active, 800 * 16);
    cfg_sel = 1'b0; bd_rate = 3'd0;
    step();
    reset = 1'b0;
    seg_fresh(cyc, 800 * 16);
    run_ticks(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
